// File: rtl/clock_prog_gen.sv
// Multi-channel programmable clock divider with a staggered reset sequencer.
// Each channel's divisor/enable is shadowed and swapped in only at its wrap point.
module clock_prog_gen #(
    parameter int CHANNELS    = 4,
    parameter int DIV_WIDTH   = 8,
    parameter int HOLD_CYCLES = 16,
    localparam int CHAN_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 sw_reset,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CHAN_W-1:0]    cfg_chan,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    input  logic                 cfg_en,
    output logic [CHANNELS-1:0]  div_clk,
    output logic [CHANNELS-1:0]  div_tick,
    output logic [CHANNELS-1:0]  rst_out,
    output logic [1:0]           seq_state
);

    localparam int HCW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } seq_t;

    seq_t                state_q, state_d;
    logic [HCW-1:0]      hold_cnt_q, hold_cnt_d;
    logic [CHAN_W-1:0]   rel_idx_q, rel_idx_d;
    logic [CHANNELS-1:0] rst_q, rst_d;
    logic                cfg_ready_q;
    logic                wr;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        rel_idx_d  = rel_idx_q;
        rst_d      = rst_q;
        if (sw_reset) begin
            state_d    = HOLD;
            hold_cnt_d = '0;
            rel_idx_d  = '0;
            rst_d      = '1;
        end else begin
            case (state_q)
                HOLD: begin
                    rst_d = '1;
                    if (hold_cnt_q == HCW'(HOLD_CYCLES)) begin
                        state_d   = RELEASE;
                        rel_idx_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                RELEASE: begin
                    rst_d[rel_idx_q] = 1'b0;
                    if (rel_idx_q == CHAN_W'(CHANNELS - 1))
                        state_d = RUN;
                    else
                        rel_idx_d = rel_idx_q + 1'b1;
                end
                RUN:     rst_d = '0;
                default: state_d = HOLD;
            endcase
        end
    end

    // cfg_ready is looked ahead from the next state so it never depends on inputs combinationally.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= HOLD;
            hold_cnt_q  <= '0;
            rel_idx_q   <= '0;
            rst_q       <= '1;
            cfg_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            rel_idx_q   <= rel_idx_d;
            rst_q       <= rst_d;
            cfg_ready_q <= (state_d != RELEASE);
        end
    end

    assign wr        = cfg_valid && cfg_ready_q;
    assign cfg_ready = cfg_ready_q;
    assign rst_out   = rst_q;
    assign seq_state = state_q;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        logic [DIV_WIDTH-1:0] cnt_q, act_div_q, sh_div_q;
        logic                 act_en_q, sh_en_q, pend_q, clk_q, tick_q;
        logic                 hit, run, wrap, halt, clk_next;

        assign hit      = wr && (cfg_chan == CHAN_W'(g));
        assign run      = act_en_q && !rst_q[g];
        assign wrap     = run && (cnt_q == act_div_q);
        // A pending disable forces the clock low at the wrap instead of toggling.
        assign halt     = pend_q && !sh_en_q;
        assign clk_next = halt ? 1'b0 : !clk_q;

        always_ff @(posedge clock) begin
            if (reset) begin
                cnt_q     <= '0;
                act_div_q <= '0;
                sh_div_q  <= '0;
                act_en_q  <= 1'b0;
                sh_en_q   <= 1'b0;
                pend_q    <= 1'b0;
                clk_q     <= 1'b0;
                tick_q    <= 1'b0;
            end else begin
                if (sw_reset) begin
                    cnt_q  <= '0;
                    clk_q  <= 1'b0;
                    tick_q <= 1'b0;
                end else if (!run) begin
                    cnt_q  <= '0;
                    clk_q  <= 1'b0;
                    tick_q <= 1'b0;
                    if (pend_q) begin
                        act_div_q <= sh_div_q;
                        act_en_q  <= sh_en_q;
                        pend_q    <= 1'b0;
                    end
                end else if (wrap) begin
                    cnt_q  <= '0;
                    clk_q  <= clk_next;
                    tick_q <= clk_next && !clk_q;
                    if (pend_q) begin
                        act_div_q <= sh_div_q;
                        act_en_q  <= sh_en_q;
                        pend_q    <= 1'b0;
                    end
                end else begin
                    cnt_q  <= cnt_q + 1'b1;
                    tick_q <= 1'b0;
                end
                // A new write wins over a transfer of the previous shadow in the same cycle.
                if (hit) begin
                    sh_div_q <= cfg_div;
                    sh_en_q  <= cfg_en;
                    pend_q   <= 1'b1;
                end
            end
        end

        assign div_clk[g]  = clk_q;
        assign div_tick[g] = tick_q;
    end

endmodule

// File: tb/tb_clock_prog_gen.sv
// Bench for clock_prog_gen: directed scenarios plus random traffic checked every
// cycle against a timeline/countdown reference model.
module tb_clock_prog_gen;

    localparam int CH = 4;
    localparam int DW = 8;
    localparam int HC = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          sw_reset = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [1:0]    cfg_chan = '0;
    logic [DW-1:0] cfg_div = '0;
    logic          cfg_en = 1'b0;
    logic [CH-1:0] div_clk, div_tick, rst_out;
    logic [1:0]    seq_state;

    clock_prog_gen #(.CHANNELS(CH), .DIV_WIDTH(DW), .HOLD_CYCLES(HC)) dut (
        .clock(clock), .reset(reset), .sw_reset(sw_reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_chan(cfg_chan),
        .cfg_div(cfg_div), .cfg_en(cfg_en), .div_clk(div_clk),
        .div_tick(div_tick), .rst_out(rst_out), .seq_state(seq_state)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_pass = 0;
    int edge_n = 0;
    bit last_acc = 0;
    bit rdy_seen = 0;

    // Reference model: sequencer as time since sequence start, channels as toggle countdowns.
    int      t = 0;
    bit      m_rdy = 0;
    bit [CH-1:0] m_clk = '0, m_tick = '0;
    int      rem[CH];
    int      a_d[CH], s_d[CH];
    bit      a_en[CH], s_en[CH], pend[CH];

    function automatic bit m_rst(int i);
        return t < HC + 2 + i;
    endfunction

    function automatic int m_seq();
        if (t <= HC) return 0;
        if (t < HC + 1 + CH) return 1;
        return 2;
    endfunction

    function automatic logic [CH-1:0] m_rst_vec();
        logic [CH-1:0] v;
        for (int i = 0; i < CH; i++) v[i] = m_rst(i);
        return v;
    endfunction

    task automatic model_step();
        bit acc;
        bit oc, r, halt;
        if (reset) begin
            t = 0; m_rdy = 0; m_clk = '0; m_tick = '0;
            for (int i = 0; i < CH; i++) begin
                rem[i] = 1; a_d[i] = 0; s_d[i] = 0;
                a_en[i] = 0; s_en[i] = 0; pend[i] = 0;
            end
            return;
        end
        acc = cfg_valid && m_rdy;
        for (int i = 0; i < CH; i++) begin
            r  = m_rst(i);
            oc = m_clk[i];
            if (sw_reset) begin
                m_clk[i] = 0; m_tick[i] = 0;
            end else if (r || !a_en[i]) begin
                m_clk[i] = 0; m_tick[i] = 0;
                if (pend[i]) begin a_d[i] = s_d[i]; a_en[i] = s_en[i]; pend[i] = 0; end
                rem[i] = a_d[i] + 1;
            end else begin
                rem[i]--;
                if (rem[i] == 0) begin
                    halt = 0;
                    if (pend[i]) begin
                        a_d[i] = s_d[i]; a_en[i] = s_en[i]; pend[i] = 0;
                        halt = !a_en[i];
                    end
                    m_clk[i]  = halt ? 1'b0 : !oc;
                    m_tick[i] = m_clk[i] && !oc;
                    rem[i]    = a_d[i] + 1;
                end else begin
                    m_tick[i] = 0;
                end
            end
        end
        if (acc && int'(cfg_chan) < CH) begin
            s_d[cfg_chan] = int'(cfg_div); s_en[cfg_chan] = cfg_en; pend[cfg_chan] = 1;
        end
        if (sw_reset) t = 0;
        else if (t < 100000) t++;
        m_rdy = (m_seq() != 1);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, edge_n);
    endtask

    task automatic step();
        @(posedge clock);
        last_acc = cfg_valid && rdy_seen;
        model_step();
        edge_n++;
        @(negedge clock);
        rdy_seen = cfg_ready;
        chk("cfg_ready", cfg_ready, m_rdy);
        chk("seq_state", seq_state, m_seq());
        chk("rst_out", rst_out, m_rst_vec());
        chk("div_clk", div_clk, m_clk);
        chk("div_tick", div_tick, m_tick);
    endtask

    task automatic run_until(input int n);
        while (edge_n < n) step();
    endtask

    task automatic cfg_write(input int ch, input int d, input bit en);
        bit done = 0;
        cfg_valid = 1; cfg_chan = 2'(ch); cfg_div = DW'(d); cfg_en = en;
        for (int k = 0; k < 60 && !done; k++) begin
            step();
            done = last_acc;
        end
        cfg_valid = 0;
        if (!done) chk("cfg_handshake_timeout", 0, 1);
    endtask

    int s_edge, n, w;

    initial begin
        reset = 1;
        step(); step();
        chk("reset_rst_out", rst_out, 4'hf);
        chk("reset_cfg_ready", cfg_ready, 0);
        chk("reset_div_clk", div_clk, 0);
        reset = 0;
        edge_n = -1;

        // Program during HOLD; the first write waits out the not-ready reset cycle.
        cfg_write(1, 2, 1);
        cfg_write(0, 3, 1);
        cfg_write(2, 1, 1);
        cfg_write(3, 0, 1);
        run_until(16);
        chk("hold_end_rst", rst_out, 4'hf);
        chk("release_state", seq_state, 1);
        chk("release_ready", cfg_ready, 0);
        run_until(17);
        chk("rst0_fall", rst_out, 4'he);
        run_until(20);
        chk("rst3_fall", rst_out, 4'h0);
        chk("run_state", seq_state, 2);
        chk("ch1_pre_rise", div_clk[1], 0);
        run_until(21);
        chk("ch1_first_rise", div_clk[1], 1);
        chk("ch1_first_tick", div_tick[1], 1);
        run_until(22);
        chk("ch1_tick_drop", div_tick[1], 0);
        run_until(24);
        chk("ch1_fall", div_clk[1], 0);
        run_until(27);
        chk("ch1_second_rise", div_clk[1], 1);

        // ch0 D=3 high from edge 29; rewrite to D=0 mid-half-period.
        run_until(30);
        cfg_write(0, 0, 1);
        run_until(32);
        chk("ch0_old_half", div_clk[0], 1);
        run_until(33);
        chk("ch0_wrap_fall", div_clk[0], 0);
        run_until(34);
        chk("ch0_fast_rise", div_clk[0], 1);
        chk("ch0_fast_tick", div_tick[0], 1);
        run_until(35);
        chk("ch0_fast_fall", div_clk[0], 0);

        // Disable ch2 while high, then re-enable with D=1.
        w = 0;
        while (div_clk[2] !== 1'b1 && w < 20) begin step(); w++; end
        chk("ch2_seen_high", div_clk[2], 1);
        cfg_write(2, 1, 0);
        repeat (10) step();
        chk("ch2_halted", div_clk[2], 0);
        repeat (10) step();
        chk("ch2_still_halted", div_clk[2], 0);
        cfg_write(2, 1, 1);
        step(); step();
        chk("ch2_restart_low", div_clk[2], 0);
        step();
        chk("ch2_restart_rise", div_clk[2], 1);

        // sw_reset in RUN with a same-cycle write to ch3.
        repeat (5) step();
        sw_reset = 1; cfg_valid = 1; cfg_chan = 2'd3; cfg_div = 8'd5; cfg_en = 1;
        step();
        sw_reset = 0; cfg_valid = 0;
        s_edge = edge_n;
        chk("sw_write_accepted", last_acc, 1);
        chk("sw_rst_all", rst_out, 4'hf);
        chk("sw_hold", seq_state, 0);
        chk("sw_clk_cleared", div_clk, 0);
        run_until(s_edge + 26);
        chk("ch3_pre_rise", div_clk[3], 0);
        run_until(s_edge + 27);
        chk("ch3_new_div_rise", div_clk[3], 1);

        // Full-scale divisor: half-period of 256 clocks.
        cfg_write(0, 255, 1);
        w = 0;
        while (!(div_tick[0] === 1'b1 && pend[0] == 0 && a_d[0] == 255) && w < 1200) begin step(); w++; end
        chk("d255_rise_seen", div_tick[0], 1);
        n = 0;
        while (div_clk[0] === 1'b1 && n < 400) begin step(); n++; end
        chk("d255_half_period", n, 256);

        // Random traffic.
        for (int c = 0; c < 2500; c++) begin
            reset     = ($urandom_range(0, 599) == 0);
            sw_reset  = ($urandom_range(0, 149) == 0);
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_chan  = 2'($urandom_range(0, 3));
            cfg_div   = ($urandom_range(0, 9) == 0) ? DW'($urandom_range(0, 40)) : DW'($urandom_range(0, 5));
            cfg_en    = ($urandom_range(0, 3) != 0);
            step();
        end
        reset = 0; sw_reset = 0; cfg_valid = 0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
